// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, DAC clock, sync/blank and coordinates.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   CNT_W    = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  output logic               PixelEn,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [CNT_W-1:0]   DrawX,
  output logic [CNT_W-1:0]   DrawY,
  output logic               LineStart,
  output logic               FrameStart,
  output logic               VBlank,
  output logic [FRAME_W-1:0] FrameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W))) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    in_range = (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic             r_vblank;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_pix_en;
  logic             w_line_tick;
  logic             w_frame_tick;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;

  assign w_pix_en     = Enable && (r_div == DIV_LAST);
  assign w_line_tick  = w_pix_en && (r_x == H_LAST);
  assign w_frame_tick = w_line_tick && (r_y == V_LAST);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_pix_en) begin
      if (r_x == H_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
      end else begin
        w_x_nxt = r_x + CNT_W'(1);
      end
    end
  end

  // Sync/blank decode from the next counter values so they line up with DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div         <= '0;
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_blank_n     <= 1'b0;
      r_vblank      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (Enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hs          <= in_range(w_x_nxt, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
      r_vs          <= in_range(w_y_nxt, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
      r_blank_n     <= (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
      r_vblank      <= (int'(w_y_nxt) >= V_ACTIVE);
      r_line_start  <= w_line_tick;
      r_frame_start <= w_frame_tick;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  // Reset to all ones so the first frame after reset reads 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt <= '1;
    end else if (w_frame_tick) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  assign FrameCount = r_frame_cnt;
`else
  assign FrameCount = '0;
`endif

  assign PixelEn     = w_pix_en;
  assign VGA_CLK     = (r_div >= DIV_HALF);
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign LineStart   = r_line_start;
  assign FrameStart  = r_frame_start;
  assign VBlank      = r_vblank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC_ON = 1;
  localparam int FCR   = 255;
`else
  localparam int FC_ON = 0;
  localparam int FCR   = 0;
`endif

  logic       Clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic       a_pe, a_vclk, a_hs, a_vs, a_bn, a_sn, a_ls, a_fs, a_vb;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_pe, b_vclk, b_hs, b_vs, b_bn, b_sn, b_ls, b_fs, b_vb;
  logic [3:0] b_x, b_y;
  logic [7:0] b_fc;

  vga_timing_gen u_dut_a (
    .Clk(Clk), .Reset(rst_a), .Enable(en_a), .PixelEn(a_pe), .VGA_CLK(a_vclk),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn),
    .DrawX(a_x), .DrawY(a_y), .LineStart(a_ls), .FrameStart(a_fs),
    .VBlank(a_vb), .FrameCount(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .CNT_W(4), .FRAME_W(8)
  ) u_dut_b (
    .Clk(Clk), .Reset(rst_b), .Enable(en_b), .PixelEn(b_pe), .VGA_CLK(b_vclk),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
    .DrawX(b_x), .DrawY(b_y), .LineStart(b_ls), .FrameStart(b_fs),
    .VBlank(b_vb), .FrameCount(b_fc)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    logic rst, en;
    int   x, y;
    logic hs, vs, bn, pe, vclk, ls, fs, vb;
    int   fc;
  } vec_t;

  vec_t vecs[14];
  int   n_cmp, n_fail;
  int   n, hs_cnt, hs_min, hs_max, bl_cnt, bl_min, vs_bad;
  int   frz_bad;
  logic sv_vclk, sv_hs;
  int   cyc, last_pe, last_fs, frames, px, py, bx, by;
  int   pe_bad, pe_cnt, x_bad, y_bad, xwrap, ywrap;
  int   hs_bad, vsb_bad, bn_bad, vb_bad, hs_hi, vs_hi;

  function automatic vec_t mk(input logic rst, input logic en, input int x, input int y,
                              input logic hs, input logic vs, input logic bn, input logic pe,
                              input logic vclk, input logic ls, input logic fs, input logic vb,
                              input int fc);
    vec_t v;
    v.rst = rst; v.en = en; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.bn = bn;
    v.pe = pe; v.vclk = vclk; v.ls = ls; v.fs = fs; v.vb = vb; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b0;

    //               rst   en    x    y    hs    vs    bn    pe    vclk  ls    fs    vb    fc
    vecs[0]  = mk(1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FCR);
    vecs[1]  = mk(1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FCR);
    vecs[2]  = mk(1'b0, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FCR);
    vecs[3]  = mk(1'b0, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    vecs[4]  = mk(1'b0, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    vecs[5]  = mk(1'b0, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[6]  = mk(1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[7]  = mk(1'b0, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    vecs[8]  = mk(1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    vecs[9]  = mk(1'b0, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[10] = mk(1'b0, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    vecs[11] = mk(1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FCR);
    vecs[12] = mk(1'b0, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FCR);
    vecs[13] = mk(1'b0, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    for (int i = 0; i < 14; i++) begin
      rst_a = vecs[i].rst;
      en_a  = vecs[i].en;
      tick();
      check($sformatf("v%0d.DrawX", i), 32'(a_x), vecs[i].x);
      check($sformatf("v%0d.DrawY", i), 32'(a_y), vecs[i].y);
      check($sformatf("v%0d.HS", i), 32'(a_hs), 32'(vecs[i].hs));
      check($sformatf("v%0d.VS", i), 32'(a_vs), 32'(vecs[i].vs));
      check($sformatf("v%0d.BLANK_N", i), 32'(a_bn), 32'(vecs[i].bn));
      check($sformatf("v%0d.PixelEn", i), 32'(a_pe), 32'(vecs[i].pe));
      check($sformatf("v%0d.VGA_CLK", i), 32'(a_vclk), 32'(vecs[i].vclk));
      check($sformatf("v%0d.LineStart", i), 32'(a_ls), 32'(vecs[i].ls));
      check($sformatf("v%0d.FrameStart", i), 32'(a_fs), 32'(vecs[i].fs));
      check($sformatf("v%0d.VBlank", i), 32'(a_vb), 32'(vecs[i].vb));
      check($sformatf("v%0d.FrameCount", i), 32'(a_fc), vecs[i].fc);
      check($sformatf("v%0d.SYNC_N", i), 32'(a_sn), 32'd0);
    end

    // One full line of the default raster, starting from (0,0).
    n = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; bl_cnt = 0; bl_min = 9999; vs_bad = 0;
    do begin
      tick();
      n++;
      if (a_hs == 1'b0) begin
        hs_cnt++;
        if (int'(a_x) < hs_min) hs_min = int'(a_x);
        if (int'(a_x) > hs_max) hs_max = int'(a_x);
      end
      if (a_bn == 1'b0) begin
        bl_cnt++;
        if (int'(a_x) < bl_min) bl_min = int'(a_x);
      end
      if (a_vs !== 1'b1 || a_vb !== 1'b0) vs_bad++;
    end while (a_ls !== 1'b1 && n < 2000);
    check("line_cycles", n, 1600);
    check("line_wrap_x", 32'(a_x), 0);
    check("line_wrap_y", 32'(a_y), 1);
    check("line_fs_clear", 32'(a_fs), 0);
    check("hs_low_cycles", hs_cnt, 192);
    check("hs_first_x", hs_min, 656);
    check("hs_last_x", hs_max, 751);
    check("blank_cycles", bl_cnt, 320);
    check("blank_first_x", bl_min, 640);
    check("vs_vblank_line0", vs_bad, 0);

    // Freeze for 10 cycles at DrawX=100.
    n = 0;
    while (a_x != 10'd100 && n < 400) begin
      tick();
      n++;
    end
    check("reach_x100", 32'(a_x), 100);
    sv_vclk = a_vclk; sv_hs = a_hs;
    en_a = 1'b0;
    frz_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (a_x != 10'd100 || a_pe !== 1'b0 || a_vclk !== sv_vclk || a_hs !== sv_hs) frz_bad++;
    end
    check("freeze", frz_bad, 0);
    en_a = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (a_x == 10'd100 && n < 5);
    check("resume_x", 32'(a_x), 101);
    check("resume_cycles", n, 2);

    // Reset at (300,1) on a PixelEn cycle.
    n = 0;
    while (!(a_x == 10'd300 && a_pe == 1'b1) && n < 1000) begin
      tick();
      n++;
    end
    check("reach_x300_pe", 32'(a_pe), 1);
    rst_a = 1'b1;
    tick();
    check("rst_mid.DrawX", 32'(a_x), 799);
    check("rst_mid.DrawY", 32'(a_y), 524);
    check("rst_mid.HS", 32'(a_hs), 1);
    check("rst_mid.VS", 32'(a_vs), 1);
    check("rst_mid.BLANK_N", 32'(a_bn), 0);
    check("rst_mid.VBlank", 32'(a_vb), 1);
    check("rst_mid.FrameCount", 32'(a_fc), FCR);
    check("rst_mid.PixelEn", 32'(a_pe), 0);

    // Small raster: positive syncs, CLK_DIV=3.
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    check("b_rst.DrawX", 32'(b_x), 13);
    check("b_rst.DrawY", 32'(b_y), 6);
    check("b_rst.HS", 32'(b_hs), 0);
    check("b_rst.VS", 32'(b_vs), 0);
    check("b_rst.BLANK_N", 32'(b_bn), 0);
    check("b_rst.VBlank", 32'(b_vb), 1);
    check("b_rst.PixelEn", 32'(b_pe), 0);
    check("b_rst.FrameCount", 32'(b_fc), FCR);
    rst_b = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (b_fs !== 1'b1 && n < 10);
    check("b_first_fs_cycles", n, 3);
    check("b_first.DrawX", 32'(b_x), 0);
    check("b_first.DrawY", 32'(b_y), 0);
    check("b_first.FrameCount", 32'(b_fc), 0);

    cyc = 0; last_pe = -1; last_fs = 0; frames = 0; px = 0; py = 0;
    pe_bad = 0; pe_cnt = 0; x_bad = 0; y_bad = 0; xwrap = 0; ywrap = 0;
    hs_bad = 0; vsb_bad = 0; bn_bad = 0; vb_bad = 0; hs_hi = 0; vs_hi = 0;
    do begin
      tick();
      cyc++;
      bx = int'(b_x);
      by = int'(b_y);
      if (b_pe === 1'b1) begin
        if (last_pe >= 0 && cyc - last_pe != 3) pe_bad++;
        last_pe = cyc;
        pe_cnt++;
      end
      if (bx != px) begin
        if (bx != ((px == 13) ? 0 : px + 1)) x_bad++;
        if (px == 13) xwrap++;
        px = bx;
      end
      if (by != py) begin
        if (by != ((py == 6) ? 0 : py + 1)) y_bad++;
        if (py == 6) ywrap++;
        py = by;
      end
      if (b_hs !== ((bx >= 10 && bx <= 11) ? 1'b1 : 1'b0)) hs_bad++;
      if (b_vs !== ((by == 5) ? 1'b1 : 1'b0)) vsb_bad++;
      if (b_bn !== ((bx < 8 && by < 4) ? 1'b1 : 1'b0)) bn_bad++;
      if (b_vb !== ((by >= 4) ? 1'b1 : 1'b0)) vb_bad++;
      if (b_hs === 1'b1) hs_hi++;
      if (b_vs === 1'b1) vs_hi++;
      if (b_fs === 1'b1) begin
        frames++;
        check($sformatf("b_frame%0d_cycles", frames), cyc - last_fs, 294);
        check($sformatf("b_frame%0d_count", frames), 32'(b_fc), FC_ON * frames);
        last_fs = cyc;
      end
    end while (frames < 2 && cyc < 1000);
    check("b_frames_seen", frames, 2);
    check("b_pe_spacing", pe_bad, 0);
    check("b_pe_count", pe_cnt, 196);
    check("b_x_step", x_bad, 0);
    check("b_x_wraps", xwrap, 14);
    check("b_y_step", y_bad, 0);
    check("b_y_wraps", ywrap, 2);
    check("b_hs_decode", hs_bad, 0);
    check("b_vs_decode", vsb_bad, 0);
    check("b_blank_decode", bn_bad, 0);
    check("b_vblank_decode", vb_bad, 0);
    check("b_hs_high_cycles", hs_hi, 84);
    check("b_vs_high_cycles", vs_hi, 84);

    n = 0;
    while (!(b_pe == 1'b1 && b_y == 4'd2) && n < 300) begin
      tick();
      n++;
    end
    check("b_reach_y2_pe", 32'(b_pe), 1);
    rst_b = 1'b1;
    tick();
    check("b_rst_mid.DrawX", 32'(b_x), 13);
    check("b_rst_mid.DrawY", 32'(b_y), 6);
    check("b_rst_mid.HS", 32'(b_hs), 0);
    check("b_rst_mid.VS", 32'(b_vs), 0);
    check("b_rst_mid.BLANK_N", 32'(b_bn), 0);
    check("b_rst_mid.FrameCount", 32'(b_fc), FCR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
